// File: rtl/dlsc_pcie_s6_tx_sched.sv
// Packet-atomic round-robin scheduler sharing the Spartan-6 PCIe 32-bit TX stream.
// Starts a TLP only with enough core buffers and yields to core config TLPs.
module dlsc_pcie_s6_tx_sched #(
    parameter int PORTS      = 3,
    parameter int MIN_BUF_AV = 2,
    parameter int MAX_BEATS  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [PORTS-1:0]      in_ready,
    input  logic [PORTS-1:0]      in_valid,
    input  logic [PORTS-1:0]      in_last,
    input  logic [32*PORTS-1:0]   in_data,
    input  logic                  pcie_tx_ready,
    output logic                  pcie_tx_valid,
    output logic                  pcie_tx_last,
    output logic [31:0]           pcie_tx_data,
    input  logic [5:0]            pcie_tx_buf_av,
    input  logic                  pcie_tx_cfg_req,
    output logic                  pcie_tx_cfg_gnt,
    output logic [PORTS-1:0]      grant,
    output logic                  overrun
);
    localparam int IW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int CW = $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_CFG} state_t;
    state_t state, state_nxt;

    logic [IW-1:0] ptr, gidx, pick;
    logic [CW-1:0] beat_cnt;
    logic          ovf_seen;
    logic          start_ok, accept, accept_last;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (int'(i) == PORTS - 1) ? '0 : i + IW'(1);
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == CW'(MAX_BEATS)) ? c : c + CW'(1);
    endfunction

    // First pass finds the lowest valid requester (wrap case); second pass
    // overrides it with the lowest valid requester at or after the pointer.
    always_comb begin
        pick = ptr;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (in_valid[i]) pick = IW'(i);
        end
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (in_valid[i] && IW'(i) >= ptr) pick = IW'(i);
        end
    end

    assign start_ok    = (|in_valid) && (pcie_tx_buf_av >= 6'(MIN_BUF_AV));
    assign accept      = (state == ST_XFER) && in_valid[gidx] && in_ready[gidx];
    assign accept_last = accept && in_last[gidx];

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pcie_tx_cfg_req) state_nxt = ST_CFG;
                else if (start_ok)   state_nxt = ST_XFER;
            end
            ST_XFER: if (accept_last)      state_nxt = ST_IDLE;
            ST_CFG:  if (!pcie_tx_cfg_req) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = '0;
        if (state == ST_XFER) in_ready[gidx] = !pcie_tx_valid || pcie_tx_ready;
    end

    // Control registers: grant, pointer, beat counter, output valid, config grant
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr             <= '0;
            gidx            <= '0;
            grant           <= '0;
            beat_cnt        <= '0;
            ovf_seen        <= 1'b0;
            overrun         <= 1'b0;
            pcie_tx_valid   <= 1'b0;
            pcie_tx_last    <= 1'b0;
            pcie_tx_cfg_gnt <= 1'b0;
        end else begin
            overrun         <= 1'b0;
            pcie_tx_cfg_gnt <= (state == ST_CFG) && pcie_tx_cfg_req && !pcie_tx_valid;
            if (accept) begin
                pcie_tx_valid <= 1'b1;
                pcie_tx_last  <= in_last[gidx];
            end else if (pcie_tx_ready) begin
                pcie_tx_valid <= 1'b0;
            end
            if (state == ST_IDLE && !pcie_tx_cfg_req && start_ok) begin
                gidx  <= pick;
                grant <= PORTS'(1) << pick;
            end
            if (accept_last) begin
                grant    <= '0;
                ptr      <= next_idx(gidx);
                beat_cnt <= '0;
                ovf_seen <= 1'b0;
            end else if (accept) begin
                beat_cnt <= sat_inc(beat_cnt);
                if (beat_cnt == CW'(MAX_BEATS) && !ovf_seen) begin
                    overrun  <= 1'b1;
                    ovf_seen <= 1'b1;
                end
            end
        end
    end

    // Output data register: loaded only on an accepted beat
    always_ff @(posedge clk) begin
        if (accept) pcie_tx_data <= in_data[32*gidx +: 32];
    end

endmodule

// File: tb/tb_dlsc_pcie_s6_tx_sched.sv
// Directed bench for dlsc_pcie_s6_tx_sched: queue-fed requesters, bus monitor,
// and one task per scenario with inline expected-value comparisons.
module tb_dlsc_pcie_s6_tx_sched;
    localparam int PORTS = 3;
    localparam int MAXB  = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [PORTS-1:0]    in_ready, in_valid, in_last;
    logic [32*PORTS-1:0] in_data;
    logic                pcie_tx_ready, pcie_tx_valid, pcie_tx_last;
    logic [31:0]         pcie_tx_data;
    logic [5:0]          pcie_tx_buf_av;
    logic                pcie_tx_cfg_req, pcie_tx_cfg_gnt;
    logic [PORTS-1:0]    grant;
    logic                overrun;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] d;
        logic        l;
        int          cyc;
    } beat_t;

    beat_t            out_q[$];
    logic [32:0]      src_q[PORTS][$];
    logic [PORTS-1:0] gnt_q[$];
    int               cyc = 0;
    int               ovf_cnt = 0, stall_err = 0, stall_cnt = 0, gnt_viol = 0, rdy_viol = 0;
    logic [31:0]      ovf_data = '0;

    always #5 clk = ~clk;

    dlsc_pcie_s6_tx_sched #(.PORTS(PORTS), .MIN_BUF_AV(2), .MAX_BEATS(MAXB)) dut (
        .clk(clk), .rst(rst),
        .in_ready(in_ready), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
        .pcie_tx_ready(pcie_tx_ready), .pcie_tx_valid(pcie_tx_valid),
        .pcie_tx_last(pcie_tx_last), .pcie_tx_data(pcie_tx_data),
        .pcie_tx_buf_av(pcie_tx_buf_av), .pcie_tx_cfg_req(pcie_tx_cfg_req),
        .pcie_tx_cfg_gnt(pcie_tx_cfg_gnt), .grant(grant), .overrun(overrun)
    );

    function automatic logic [31:0] w(input int p, input int k, input int b);
        return {16'hC0DE, 4'(p), 8'(k), 4'(b)};
    endfunction

    task automatic push_tlp(input int p, input int k, input int n);
        for (int b = 0; b < n; b++) src_q[p].push_back({(b == n - 1), w(p, k, b)});
    endtask

    task automatic clear_mon();
        out_q.delete();
        gnt_q.delete();
        ovf_cnt = 0; stall_err = 0; stall_cnt = 0; gnt_viol = 0; rdy_viol = 0;
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int c = 0; c < budget && out_q.size() < n; c++) @(posedge clk);
        #1;
    endtask

    // Requester model: holds each queued beat on in_* until it is handshaken.
    initial begin
        logic [PORTS-1:0] hs;
        in_valid = '0; in_last = '0; in_data = '0;
        forever begin
            @(negedge clk);
            hs = in_valid & in_ready;
            @(posedge clk); #1;
            for (int i = 0; i < PORTS; i++) begin
                if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    in_valid[i] = 1'b1;
                    in_last[i]  = src_q[i][0][32];
                    in_data[32*i +: 32] = src_q[i][0][31:0];
                end else begin
                    in_valid[i] = 1'b0;
                    in_last[i]  = 1'b0;
                end
            end
        end
    end

    // Bus monitor sampled on the falling edge.
    initial begin
        logic pv, pr, pl;
        logic [31:0] pd;
        logic [PORTS-1:0] pg;
        pv = 0; pr = 0; pl = 0; pd = '0; pg = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst === 1'b0) begin
                if (pcie_tx_valid && pcie_tx_ready)
                    out_q.push_back('{d: pcie_tx_data, l: pcie_tx_last, cyc: cyc});
                if (grant != 0 && pg == 0) gnt_q.push_back(grant);
                if (overrun) begin ovf_cnt++; ovf_data = pcie_tx_data; end
                if (pcie_tx_valid && !pcie_tx_ready) stall_cnt++;
                if (pv && !pr && (!pcie_tx_valid || pcie_tx_data != pd || pcie_tx_last != pl))
                    stall_err++;
                if (pcie_tx_cfg_gnt && pcie_tx_valid) gnt_viol++;
                if (pcie_tx_cfg_gnt && in_ready != 0) rdy_viol++;
            end
            pv = pcie_tx_valid; pr = pcie_tx_ready; pd = pcie_tx_data; pl = pcie_tx_last; pg = grant;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (pcie_tx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pcie_tx_valid); end
        total++; if (pcie_tx_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b exp=0", pcie_tx_last); end
        total++; if (pcie_tx_cfg_gnt !== 1'b0) begin bad++; $display("FAIL reset_cfg_gnt got=%b exp=0", pcie_tx_cfg_gnt); end
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL reset_grant got=%b exp=000", grant); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        total++; if (in_ready !== 3'b000) begin bad++; $display("FAIL reset_in_ready got=%b exp=000", in_ready); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_two_ports();
        logic [31:0] ed;
        logic        el;
        int          eg;
        clear_mon();
        @(posedge clk); #2;
        push_tlp(0, 1, 4);
        push_tlp(2, 1, 4);
        wait_words(8, 40);
        total++; if (out_q.size() != 8) begin bad++; $display("FAIL two_ports_count got=%0d exp=8", out_q.size()); end
        for (int i = 0; i < 8 && i < out_q.size(); i++) begin
            ed = (i < 4) ? w(0, 1, i) : w(2, 1, i - 4);
            el = (i == 3 || i == 7);
            total++;
            if (out_q[i].d !== ed || out_q[i].l !== el) begin
                bad++; $display("FAIL two_ports_word%0d got=%h/%b exp=%h/%b", i, out_q[i].d, out_q[i].l, ed, el);
            end
        end
        for (int i = 1; i < 8 && i < out_q.size(); i++) begin
            eg = (i == 4) ? 2 : 1;
            total++;
            if (out_q[i].cyc - out_q[i-1].cyc != eg) begin
                bad++; $display("FAIL two_ports_spacing%0d got=%0d exp=%0d", i, out_q[i].cyc - out_q[i-1].cyc, eg);
            end
        end
        total++;
        if (gnt_q.size() != 2 || gnt_q[0] !== 3'b001 || gnt_q[1] !== 3'b100) begin
            bad++; $display("FAIL two_ports_grants got=%0d entries first=%b exp=2 entries 001,100", gnt_q.size(), (gnt_q.size() > 0) ? gnt_q[0] : 3'bxxx);
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_round_robin();
        logic [PORTS-1:0] eg[6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        logic [31:0] ed;
        clear_mon();
        @(posedge clk); #2;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < PORTS; p++) push_tlp(p, 2 + k, 2);
        wait_words(12, 80);
        total++; if (out_q.size() != 12) begin bad++; $display("FAIL rr_count got=%0d exp=12", out_q.size()); end
        for (int i = 0; i < 12 && i < out_q.size(); i++) begin
            ed = w((i / 2) % 3, 2 + i / 6, i % 2);
            total++;
            if (out_q[i].d !== ed || out_q[i].l !== (i % 2 == 1)) begin
                bad++; $display("FAIL rr_word%0d got=%h/%b exp=%h/%b", i, out_q[i].d, out_q[i].l, ed, (i % 2 == 1));
            end
        end
        total++; if (gnt_q.size() != 6) begin bad++; $display("FAIL rr_grant_count got=%0d exp=6", gnt_q.size()); end
        for (int i = 0; i < 6 && i < gnt_q.size(); i++) begin
            total++;
            if (gnt_q[i] !== eg[i]) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", i, gnt_q[i], eg[i]); end
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_buf_av();
        int g_err = 0;
        clear_mon();
        pcie_tx_buf_av = 6'd1;
        @(posedge clk); #2;
        push_tlp(1, 5, 3);
        repeat (10) begin
            @(posedge clk); #1;
            if (grant !== 3'b000) g_err++;
        end
        total++; if (g_err != 0) begin bad++; $display("FAIL bufav_low_grant got=%0d granted cycles exp=0", g_err); end
        total++; if (out_q.size() != 0) begin bad++; $display("FAIL bufav_low_words got=%0d exp=0", out_q.size()); end
        pcie_tx_buf_av = 6'd2;
        @(posedge clk); #1;
        total++; if (grant !== 3'b010) begin bad++; $display("FAIL bufav_grant got=%b exp=010", grant); end
        pcie_tx_buf_av = 6'd0;
        wait_words(3, 30);
        total++; if (out_q.size() != 3) begin bad++; $display("FAIL bufav_drop_count got=%0d exp=3", out_q.size()); end
        for (int i = 0; i < 3 && i < out_q.size(); i++) begin
            total++;
            if (out_q[i].d !== w(1, 5, i)) begin bad++; $display("FAIL bufav_word%0d got=%h exp=%h", i, out_q[i].d, w(1, 5, i)); end
        end
        pcie_tx_buf_av = 6'd8;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_ready_toggle();
        bit rp[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        clear_mon();
        @(posedge clk); #2;
        push_tlp(0, 6, 5);
        for (int c = 0; c < 60 && out_q.size() < 5; c++) begin
            @(posedge clk); #1;
            pcie_tx_ready = rp[c % 4];
        end
        pcie_tx_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        total++; if (out_q.size() != 5) begin bad++; $display("FAIL ready_count got=%0d exp=5", out_q.size()); end
        for (int i = 0; i < 5 && i < out_q.size(); i++) begin
            total++;
            if (out_q[i].d !== w(0, 6, i) || out_q[i].l !== (i == 4)) begin
                bad++; $display("FAIL ready_word%0d got=%h/%b exp=%h/%b", i, out_q[i].d, out_q[i].l, w(0, 6, i), (i == 4));
            end
        end
        total++; if (stall_cnt == 0) begin bad++; $display("FAIL ready_stalled got=%0d stall cycles exp>0", stall_cnt); end
        total++; if (stall_err != 0) begin bad++; $display("FAIL ready_hold got=%0d changes exp=0", stall_err); end
        total++; if (ovf_cnt != 0) begin bad++; $display("FAIL ready_overrun got=%0d exp=0", ovf_cnt); end
    endtask

    task automatic test_cfg();
        clear_mon();
        @(posedge clk); #2;
        push_tlp(1, 7, 4);
        for (int c = 0; c < 20 && grant !== 3'b010; c++) begin @(posedge clk); #1; end
        repeat (2) begin @(posedge clk); #1; end
        pcie_tx_cfg_req = 1'b1;
        push_tlp(0, 8, 2);
        @(posedge clk); #1;
        total++; if (grant !== 3'b010) begin bad++; $display("FAIL cfg_grant_lock got=%b exp=010", grant); end
        total++; if (pcie_tx_cfg_gnt !== 1'b0) begin bad++; $display("FAIL cfg_gnt_early got=%b exp=0", pcie_tx_cfg_gnt); end
        wait_words(4, 20);
        for (int c = 0; c < 20 && pcie_tx_cfg_gnt !== 1'b1; c++) begin @(posedge clk); #1; end
        total++; if (pcie_tx_cfg_gnt !== 1'b1) begin bad++; $display("FAIL cfg_gnt_rise got=%b exp=1", pcie_tx_cfg_gnt); end
        repeat (5) @(posedge clk);
        #1;
        total++; if (out_q.size() != 4) begin bad++; $display("FAIL cfg_hold_words got=%0d exp=4", out_q.size()); end
        total++; if (pcie_tx_cfg_gnt !== 1'b1) begin bad++; $display("FAIL cfg_gnt_hold got=%b exp=1", pcie_tx_cfg_gnt); end
        total++; if (in_ready !== 3'b000) begin bad++; $display("FAIL cfg_in_ready got=%b exp=000", in_ready); end
        pcie_tx_cfg_req = 1'b0;
        @(posedge clk); #1;
        total++; if (pcie_tx_cfg_gnt !== 1'b0) begin bad++; $display("FAIL cfg_gnt_fall got=%b exp=0", pcie_tx_cfg_gnt); end
        wait_words(6, 20);
        total++; if (out_q.size() != 6) begin bad++; $display("FAIL cfg_words got=%0d exp=6", out_q.size()); end
        for (int i = 0; i < 6 && i < out_q.size(); i++) begin
            total++;
            if (out_q[i].d !== ((i < 4) ? w(1, 7, i) : w(0, 8, i - 4))) begin
                bad++; $display("FAIL cfg_word%0d got=%h exp=%h", i, out_q[i].d, (i < 4) ? w(1, 7, i) : w(0, 8, i - 4));
            end
        end
        total++; if (gnt_viol != 0) begin bad++; $display("FAIL cfg_gnt_with_valid got=%0d exp=0", gnt_viol); end
        total++; if (rdy_viol != 0) begin bad++; $display("FAIL cfg_ready_with_gnt got=%0d exp=0", rdy_viol); end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_overrun_reset();
        int n0;
        clear_mon();
        @(posedge clk); #2;
        push_tlp(2, 9, 6);
        wait_words(6, 40);
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_q.size() != 6) begin bad++; $display("FAIL ovr_count got=%0d exp=6", out_q.size()); end
        for (int i = 0; i < 6 && i < out_q.size(); i++) begin
            total++;
            if (out_q[i].d !== w(2, 9, i)) begin bad++; $display("FAIL ovr_word%0d got=%h exp=%h", i, out_q[i].d, w(2, 9, i)); end
        end
        total++; if (ovf_cnt != 1) begin bad++; $display("FAIL ovr_pulses got=%0d exp=1", ovf_cnt); end
        total++; if (ovf_data !== w(2, 9, 4)) begin bad++; $display("FAIL ovr_beat got=%h exp=%h", ovf_data, w(2, 9, 4)); end

        clear_mon();
        @(posedge clk); #2;
        push_tlp(0, 10, 6);
        wait_words(3, 30);
        #1;
        rst = 1'b1;
        src_q[0].delete();
        n0 = out_q.size();
        @(posedge clk); #1;
        total++; if (pcie_tx_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", pcie_tx_valid); end
        total++; if (grant !== 3'b000) begin bad++; $display("FAIL rst_mid_grant got=%b exp=000", grant); end
        total++; if (in_ready !== 3'b000) begin bad++; $display("FAIL rst_mid_in_ready got=%b exp=000", in_ready); end
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++; if (n0 != 3) begin bad++; $display("FAIL rst_mid_before got=%0d exp=3", n0); end
        total++; if (out_q.size() != n0) begin bad++; $display("FAIL rst_mid_after got=%0d exp=%0d", out_q.size(), n0); end
        total++; if (pcie_tx_valid !== 1'b0 || grant !== 3'b000) begin
            bad++; $display("FAIL rst_mid_quiet got=%b/%b exp=0/000", pcie_tx_valid, grant);
        end
    endtask

    initial begin
        rst = 1'b1;
        pcie_tx_ready = 1'b1;
        pcie_tx_buf_av = 6'd8;
        pcie_tx_cfg_req = 1'b0;
        test_reset();
        test_two_ports();
        test_round_robin();
        test_buf_av();
        test_ready_toggle();
        test_cfg();
        test_overrun_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dlsc_pcie_s6_tx_sched.md
Name: dlsc_pcie_s6_tx_sched

Overview:
- Packet-atomic round-robin scheduler that shares the single 32-bit Spartan-6 PCIe TLP transmit stream between PORTS requesters (inbound completions, outbound requests, DMA engines).
- Starts a new TLP only when the core reports enough transmit buffers.
- Yields to core-internal config TLPs through the tx_cfg_req/tx_cfg_gnt handshake.
- Sits directly in front of the core's s_axis_tx interface and drives it through one output register stage.

Parameters:
- PORTS, 3, number of requesters (2..8)
- MIN_BUF_AV, 2, minimum pcie_tx_buf_av required to start a TLP
- MAX_BEATS, 1024, maximum beats per TLP; a longer TLP flags an overrun

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_ready  out  PORTS  per-requester ready
- in_valid  in  PORTS  per-requester valid
- in_last  in  PORTS  per-requester last beat of TLP
- in_data  in  32*PORTS  per-requester data; requester i uses bits [32*i+31:32*i]
- pcie_tx_ready  in  1  s_axis_tx_tready
- pcie_tx_valid  out  1  s_axis_tx_tvalid (registered)
- pcie_tx_last  out  1  s_axis_tx_tlast (registered)
- pcie_tx_data  out  32  s_axis_tx_tdata (registered)
- pcie_tx_buf_av  in  6  tx_buf_av
- pcie_tx_cfg_req  in  1  tx_cfg_req
- pcie_tx_cfg_gnt  out  1  tx_cfg_gnt (registered)
- grant  out  PORTS  one-hot owner of the current TLP (registered)
- overrun  out  1  one-cycle pulse when a TLP exceeds MAX_BEATS

Behaviour:
- Reset values:
  - pcie_tx_valid=0, pcie_tx_last=0, pcie_tx_cfg_gnt=0, grant=0, overrun=0
  - state=ST_IDLE; round-robin pointer = requester 0 has top priority
  - beat counter=0; pcie_tx_data is don't-care.
- Reset mid-TLP abandons the packet immediately; no further beats are issued.
- States: ST_IDLE, ST_XFER, ST_CFG.
- ST_IDLE:
  - If pcie_tx_cfg_req=1: go to ST_CFG. Config has priority over a pending start in the same cycle.
  - Else, if any in_valid and pcie_tx_buf_av >= MIN_BUF_AV: pick the first valid requester at or after the pointer (wrapping modulo PORTS), set grant to it (one-hot), go to ST_XFER. No beat is accepted in the arbitration cycle.
- ST_XFER:
  - in_ready[g] = (!pcie_tx_valid || pcie_tx_ready); all other in_ready = 0.
  - On in_valid[g] && in_ready[g]: load the data and last beat into the output register and set pcie_tx_valid=1.
  - Latency from input to output is 1 cycle. Full throughput is 1 beat/cycle.
  - pcie_tx_valid clears on pcie_tx_ready unless it is reloaded in the same cycle.
  - On an accepted last beat:
    - pointer = g+1 mod PORTS; grant=0; go to ST_IDLE.
    - Back-to-back TLPs therefore carry one idle arbitration cycle.
- Grant lock:
  - The grant never changes mid-TLP.
  - pcie_tx_buf_av and pcie_tx_cfg_req are ignored until the last beat is accepted.
- Beat counter:
  - Counts accepted beats and resets to 0 on the last beat.
  - Saturates at MAX_BEATS.
  - When accepting beat number MAX_BEATS+1 (not last): pulse overrun for 1 cycle; the transfer continues.
- ST_CFG:
  - Wait until pcie_tx_valid=0, i.e. the core has drained the register. Then assert pcie_tx_cfg_gnt=1.
  - Hold pcie_tx_cfg_gnt while pcie_tx_cfg_req=1. All in_ready=0.
  - When pcie_tx_cfg_req falls: pcie_tx_cfg_gnt=0 the next cycle; return to ST_IDLE.
  - pcie_tx_cfg_gnt is never asserted while pcie_tx_valid=1 or while in ST_XFER.
- Output stability: while pcie_tx_valid=1 && !pcie_tx_ready, pcie_tx_data and pcie_tx_last hold stable.
- pcie_tx_buf_av drop: only gates starts. A drop during ST_XFER has no effect.
- Simultaneous events:
  - cfg_req rising in the same cycle a last beat is accepted: the scheduler goes to ST_IDLE, then ST_CFG on the next cycle.
  - Only the granted requester's in_valid matters in ST_XFER.

Test Plan:
- PORTS=3; requesters 0 and 2 each hold one 4-beat TLP, pointer=0 -> requester 0's 4 beats leave back-to-back, 1 idle cycle, then requester 2's 4 beats; grant = 3'b001 then 3'b100.
- All 3 requesters continuously valid with 2-beat TLPs, over 6 packets -> grant order 0,1,2,0,1,2; no interleaving within a TLP.
- pcie_tx_buf_av=1, requester 1 valid -> no grant for 10 cycles; raise buf_av to 2 -> grant=3'b010 the next cycle; drop buf_av to 0 mid-TLP -> TLP completes.
- pcie_tx_ready toggled 1,0,0,1 during a 5-beat TLP -> data on the bus is held while ready=0; all 5 words arrive in order with no loss or duplication.
- cfg_req asserted at beat 2 of a 4-beat TLP -> TLP finishes; cfg_gnt rises only after pcie_tx_valid=0; in_ready=0 while cfg_gnt=1; gnt drops the cycle after req falls.
- MAX_BEATS=4 with a 6-beat TLP -> overrun pulses exactly once, on beat 5; all 6 beats are delivered. Assert rst at beat 3 of a later TLP -> pcie_tx_valid=0 and grant=0 the next cycle.
